sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_if.sv | 34 +++
 rtl/sram_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Request/response bundle between the two bus masters (fetch m0, data m1) and sram_ctrl.
// Handshake: a master raises req with stable addr/we/be_n/wdata and holds them until ack;
// ack is a one-cycle pulse, and req still high in the cycle after ack is a new request.
interface sram_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_ack_o;

    logic                m1_req_i;
    logic                m1_we_i;
    logic [DATA_W/8-1:0] m1_be_n_i;
    logic [ADDR_W-1:0]   m1_addr_i;
    logic [DATA_W-1:0]   m1_wdata_i;
    logic [DATA_W-1:0]   m1_rdata_o;
    logic                m1_ack_o;

    modport master (
        output m0_req_i, m0_addr_i,
        input  m0_rdata_o, m0_ack_o,
        output m1_req_i, m1_we_i, m1_be_n_i, m1_addr_i, m1_wdata_i,
        input  m1_rdata_o, m1_ack_o
    );

    modport slave (
        input  m0_req_i, m0_addr_i,
        output m0_rdata_o, m0_ack_o,
        input  m1_req_i, m1_we_i, m1_be_n_i, m1_addr_i, m1_wdata_i,
        output m1_rdata_o, m1_ack_o
    );
endinterface

// File: rtl/sram_ctrl.sv
// Two-master asynchronous SRAM controller, one access in flight, all pins registered.
// Define SRAM_CTRL_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module sram_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    sram_ctrl_if.slave          bus,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W/8-1:0] sram_be_n_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    output logic                sram_data_oe_o,
    input  logic [DATA_W-1:0]   sram_rdata_i,
    output logic [2:0]          dbg_state_o
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [3:0]      cnt_q;
    logic            gnt_m1_q;
    logic            we_q;
    logic [BE_W-1:0] be_n_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic            m0_ack_q, m1_ack_q;

    logic            any_req, grant_now, pick_m1;
    logic            sel_m1, sel_we;
    logic [BE_W-1:0] sel_be_n;

    logic            ce_n_d, oe_n_d, we_n_d, data_oe_d;
    logic [BE_W-1:0] be_n_d;
    logic            m0_ack_d, m1_ack_d;

    assign any_req   = bus.m0_req_i | bus.m1_req_i;
    assign grant_now = (state_q == S_IDLE) && any_req;

`ifdef SRAM_CTRL_RR_EN
    // last_m1_q: 1 when m1 received the most recent grant.
    logic last_m1_q;
    assign pick_m1 = bus.m1_req_i & (~bus.m0_req_i | ~last_m1_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_m1_q <= 1'b1;
        end else if (grant_now) begin
            last_m1_q <= pick_m1;
        end
    end
`else
    assign pick_m1 = bus.m1_req_i;
`endif

    // On the grant edge the pins must already reflect the incoming request.
    assign sel_m1   = grant_now ? pick_m1 : gnt_m1_q;
    assign sel_we   = grant_now ? (pick_m1 & bus.m1_we_i) : we_q;
    assign sel_be_n = grant_now ? bus.m1_be_n_i : be_n_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (any_req) state_d = sel_we ? S_WR_SETUP : S_RD;
            S_RD:       if (cnt_q == 4'd0) state_d = S_DONE;
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Pin values for the cycle about to start; registered below.
    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        be_n_d    = '1;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        case (state_d)
            S_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            S_WR_SETUP: begin
                ce_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = sel_be_n;
            end
            S_WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = sel_be_n;
            end
            S_DONE: begin
                m0_ack_d = ~sel_m1;
                m1_ack_d = sel_m1;
                if (sel_we) begin
                    ce_n_d    = 1'b0;
                    data_oe_d = 1'b1;
                    be_n_d    = sel_be_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_data_oe_o <= 1'b0;
            sram_be_n_o    <= '1;
            sram_addr_o    <= '0;
            sram_wdata_o   <= '0;
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;
        end else begin
            sram_ce_n_o    <= ce_n_d;
            sram_oe_n_o    <= oe_n_d;
            sram_we_n_o    <= we_n_d;
            sram_data_oe_o <= data_oe_d;
            sram_be_n_o    <= be_n_d;
            m0_ack_q       <= m0_ack_d;
            m1_ack_q       <= m1_ack_d;
            if (grant_now) begin
                sram_addr_o <= pick_m1 ? bus.m1_addr_i : bus.m0_addr_i;
                if (pick_m1 && bus.m1_we_i) sram_wdata_o <= bus.m1_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gnt_m1_q <= 1'b0;
            we_q     <= 1'b0;
            be_n_q   <= '1;
        end else if (grant_now) begin
            gnt_m1_q <= pick_m1;
            we_q     <= pick_m1 & bus.m1_we_i;
            be_n_q   <= bus.m1_be_n_i;
        end
    end

    // Wait counter: reloaded on entry to a timed state, the state exits when it reads zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 4'd0;
        end else if ((state_d == S_RD && state_q != S_RD) ||
                     (state_d == S_WR_PULSE && state_q != S_WR_PULSE)) begin
            cnt_q <= CNT_RELOAD;
        end else if ((state_q == S_RD || state_q == S_WR_PULSE) && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (state_q == S_RD && cnt_q == 4'd0) begin
            if (gnt_m1_q) m1_rdata_q <= sram_rdata_i;
            else          m0_rdata_q <= sram_rdata_i;
        end
    end

    assign bus.m0_rdata_o = m0_rdata_q;
    assign bus.m1_rdata_o = m1_rdata_q;
    assign bus.m0_ack_o   = m0_ack_q;
    assign bus.m1_ack_o   = m1_ack_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with WAIT_CYC=1 (fetch timing) and one with
// WAIT_CYC=3 backed by a 16-word byte-writable SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus_a ();
  sram_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus_b ();

  logic [19:0] a_addr, b_addr;
  logic [3:0]  a_be_n, b_be_n;
  logic        a_ce_n, a_oe_n, a_we_n, a_doe;
  logic        b_ce_n, b_oe_n, b_we_n, b_doe;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [2:0]  a_state, b_state;

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(1)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_a),
    .sram_addr_o(a_addr), .sram_be_n_o(a_be_n), .sram_ce_n_o(a_ce_n),
    .sram_oe_n_o(a_oe_n), .sram_we_n_o(a_we_n), .sram_wdata_o(a_wdata),
    .sram_data_oe_o(a_doe), .sram_rdata_i(a_rdata), .dbg_state_o(a_state)
  );

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(3)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_b),
    .sram_addr_o(b_addr), .sram_be_n_o(b_be_n), .sram_ce_n_o(b_ce_n),
    .sram_oe_n_o(b_oe_n), .sram_we_n_o(b_we_n), .sram_wdata_o(b_wdata),
    .sram_data_oe_o(b_doe), .sram_rdata_i(b_rdata), .dbg_state_o(b_state)
  );

  // Fetch-side SRAM: only word 0x00010 holds the instruction of interest.
  assign a_rdata = (a_addr == 20'h00010) ? 32'h02A00413 : 32'hBAD0BAD0;

  // Data-side SRAM model, reloaded with 0x1111000i while reset is asserted.
  logic [31:0] mem [16];
  assign b_rdata = mem[b_addr[3:0]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h11110000 | i;
    end else if (!b_ce_n && !b_we_n) begin
      for (int k = 0; k < 4; k++)
        if (!b_be_n[k]) mem[b_addr[3:0]][8*k +: 8] <= b_wdata[8*k +: 8];
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic rr_last_m1 = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic idle_inputs();
    bus_a.m0_req_i = 1'b0; bus_a.m0_addr_i = '0;
    bus_a.m1_req_i = 1'b0; bus_a.m1_we_i = 1'b0; bus_a.m1_be_n_i = '1;
    bus_a.m1_addr_i = '0;  bus_a.m1_wdata_i = '0;
    bus_b.m0_req_i = 1'b0; bus_b.m0_addr_i = '0;
    bus_b.m1_req_i = 1'b0; bus_b.m1_we_i = 1'b0; bus_b.m1_be_n_i = '1;
    bus_b.m1_addr_i = '0;  bus_b.m1_wdata_i = '0;
  endtask

  // Called 1 ns after a rising edge; cycle 0 is the grant cycle.
  task automatic xact_b(input logic m1, input logic we, input logic [3:0] be_n,
                        input logic [19:0] addr, input logic [31:0] wdata,
                        output int ack_cyc, output logic ack_m1,
                        output int oe_cyc, output int we_cyc, output int doe_cyc,
                        output logic [3:0] be_seen, output logic [31:0] wd_seen);
    ack_cyc = -1; ack_m1 = 1'b0; oe_cyc = 0; we_cyc = 0; doe_cyc = 0;
    be_seen = '1; wd_seen = '0;
    if (m1) begin
      bus_b.m1_req_i = 1'b1; bus_b.m1_we_i = we; bus_b.m1_be_n_i = be_n;
      bus_b.m1_addr_i = addr; bus_b.m1_wdata_i = wdata;
    end else begin
      bus_b.m0_req_i = 1'b1; bus_b.m0_addr_i = addr;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!b_oe_n) oe_cyc++;
      if (!b_we_n) begin we_cyc++; be_seen = b_be_n; wd_seen = b_wdata; end
      if (b_doe) doe_cyc++;
      if (bus_b.m0_ack_o || bus_b.m1_ack_o) begin
        ack_cyc = c; ack_m1 = bus_b.m1_ack_o; break;
      end
    end
    @(posedge clk); #1;
    bus_b.m0_req_i = 1'b0; bus_b.m1_req_i = 1'b0; bus_b.m1_we_i = 1'b0;
    rr_last_m1 = m1;
  endtask

  int ack_c, oe_c, we_c, doe_c, n_ack, last_c, first_c;
  logic ack_m1, exp_m1, ack_seen, found;
  logic [3:0]  be_s;
  logic [31:0] wd_s;

  initial begin
    idle_inputs();
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ce_n", b_ce_n, 1'b1);
    check_eq("rst_oe_n", b_oe_n, 1'b1);
    check_eq("rst_we_n", b_we_n, 1'b1);
    check_eq("rst_be_n", b_be_n, 4'hF);
    check_eq("rst_doe", b_doe, 1'b0);
    check_eq("rst_addr", b_addr, 20'h0);
    check_eq("rst_wdata", b_wdata, 32'h0);
    check_eq("rst_acks", {bus_b.m0_ack_o, bus_b.m1_ack_o, bus_a.m0_ack_o, bus_a.m1_ack_o}, 4'h0);
    check_eq("rst_rdata", bus_b.m0_rdata_o | bus_b.m1_rdata_o, 32'h0);
    check_eq("rst_state_a", a_state, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch read, WAIT_CYC=1
    bus_a.m0_req_i = 1'b1; bus_a.m0_addr_i = 20'h00010;
    ack_c = -1; oe_c = 0; be_s = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!a_oe_n) begin oe_c++; be_s = a_be_n; end
      if (bus_a.m0_ack_o) begin ack_c = c; break; end
    end
    @(posedge clk); #1;
    bus_a.m0_req_i = 1'b0;
    check_eq("a_ack_cyc", ack_c, 2);
    check_eq("a_oe_cyc", oe_c, 1);
    check_eq("a_rd_be_n", be_s, 4'h0);
    check_eq("a_rdata", bus_a.m0_rdata_o, 32'h02A00413);

    // Data write, WAIT_CYC=3
    xact_b(1'b1, 1'b1, 4'b1100, 20'h00004, 32'hDEADBEEF, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("wr_ack_cyc", ack_c, 5);
    check_eq("wr_ack_m1", ack_m1, 1'b1);
    check_eq("wr_we_cyc", we_c, 3);
    check_eq("wr_doe_cyc", doe_c, 5);
    check_eq("wr_oe_cyc", oe_c, 0);
    check_eq("wr_be_n", be_s, 4'b1100);
    check_eq("wr_wdata", wd_s, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("wr_doe_off", b_doe, 1'b0);
    check_eq("wr_ce_off", b_ce_n, 1'b1);
    @(posedge clk); #1;

    // Reads, write leaves m1 read data alone
    xact_b(1'b1, 1'b0, 4'hF, 20'h00004, 32'h0, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("rd1_ack_cyc", ack_c, 4);
    check_eq("rd1_oe_cyc", oe_c, 3);
    check_eq("rd1_rdata", bus_b.m1_rdata_o, 32'h1111BEEF);
    xact_b(1'b0, 1'b0, 4'hF, 20'h00005, 32'h0, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("rd0_ack_m1", ack_m1, 1'b0);
    check_eq("rd0_rdata", bus_b.m0_rdata_o, 32'h11110005);
    check_eq("rd0_m1_hold", bus_b.m1_rdata_o, 32'h1111BEEF);
    xact_b(1'b1, 1'b1, 4'b0000, 20'h00006, 32'h12345678, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("wr2_m1_hold", bus_b.m1_rdata_o, 32'h1111BEEF);
    xact_b(1'b0, 1'b0, 4'hF, 20'h00006, 32'h0, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("rd2_rdata", bus_b.m0_rdata_o, 32'h12345678);

    // Both masters held high for four transactions
    bus_b.m0_req_i = 1'b1; bus_b.m0_addr_i = 20'h00003;
    bus_b.m1_req_i = 1'b1; bus_b.m1_we_i = 1'b0; bus_b.m1_addr_i = 20'h00002;
    n_ack = 0; last_c = 0;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      @(negedge clk);
      if (bus_b.m0_ack_o || bus_b.m1_ack_o) begin
`ifdef SRAM_CTRL_RR_EN
        exp_m1 = ~rr_last_m1;
`else
        exp_m1 = 1'b1;
`endif
        rr_last_m1 = exp_m1;
        check_eq("arb_grant", bus_b.m1_ack_o, exp_m1);
        check_eq("arb_single", bus_b.m0_ack_o & bus_b.m1_ack_o, 1'b0);
        if (bus_b.m1_ack_o) check_eq("arb_data_m1", bus_b.m1_rdata_o, 32'h11110002);
        else                check_eq("arb_data_m0", bus_b.m0_rdata_o, 32'h11110003);
        check_eq("arb_spacing", c - last_c, (n_ack == 0) ? 4 : 5);
        last_c = c;
        n_ack++;
      end
    end
    check_eq("arb_count", n_ack, 4);
    @(posedge clk); #1;
    bus_b.m0_req_i = 1'b0; bus_b.m1_req_i = 1'b0;

    // Back-to-back fetch reads with req held through ack
    bus_b.m0_req_i = 1'b1; bus_b.m0_addr_i = 20'h00001;
    n_ack = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && n_ack < 2; c++) begin
      @(negedge clk);
      if (bus_b.m0_ack_o) begin
        if (n_ack == 0) first_c = c; else last_c = c;
        n_ack++;
      end
    end
    @(posedge clk); #1;
    bus_b.m0_req_i = 1'b0;
    rr_last_m1 = 1'b0;
    check_eq("b2b_first_ack", first_c, 4);
    check_eq("b2b_second_ack", last_c, 9);
    check_eq("b2b_rdata", bus_b.m0_rdata_o, 32'h11110001);

    // Reset during the write pulse
    bus_b.m1_req_i = 1'b1; bus_b.m1_we_i = 1'b1; bus_b.m1_be_n_i = 4'h0;
    bus_b.m1_addr_i = 20'h00007; bus_b.m1_wdata_i = 32'hCAFEF00D;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!b_we_n) begin found = 1'b1; break; end
    end
    check_eq("rst_pulse_seen", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_we_n", b_we_n, 1'b1);
    check_eq("arst_ce_n", b_ce_n, 1'b1);
    check_eq("arst_doe", b_doe, 1'b0);
    check_eq("arst_state", b_state, 3'd0);
    bus_b.m1_req_i = 1'b0; bus_b.m1_we_i = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ack_seen = ack_seen | bus_b.m0_ack_o | bus_b.m1_ack_o;
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    ack_seen = ack_seen | bus_b.m0_ack_o | bus_b.m1_ack_o;
    check_eq("arst_no_ack", ack_seen, 1'b0);
    @(posedge clk); #1;
    rr_last_m1 = 1'b1;
    xact_b(1'b1, 1'b0, 4'hF, 20'h00007, 32'h0, ack_c, ack_m1, oe_c, we_c, doe_c, be_s, wd_s);
    check_eq("post_rst_ack_cyc", ack_c, 4);
    check_eq("post_rst_rdata", bus_b.m1_rdata_o, 32'h11110007);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
